buzzer_multi_axi: RTL and testbench

- AXI4-Lite slave tone generator with NUM_CH independent buzzer channels; successor to the single-channel BUZZER IP.
- Each channel produces a square wave of programmable half-period for a programmable number of full cycles, then stops and flags done.
- Sits behind the PS/master AXI interconnect; the buzzer outputs go to package pins.

---
 rtl/buzzer_pkg.sv | 32 +++
 rtl/buzzer_multi_axi_tone_ch.sv | 86 ++++++++
 rtl/buzzer_multi_axi.sv | 192 +++++++++++++++++++
 tb/tb_buzzer_multi_axi.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared register map, control-bit positions and channel state type for the
// multi-channel AXI4-Lite buzzer.
package buzzer_pkg;

  localparam int unsigned CTRL_OFF   = 'h00;
  localparam int unsigned STATUS_OFF = 'h04;
  localparam int unsigned CH_BASE    = 'h08;
  localparam int unsigned CH_STRIDE  = 8;

  localparam int unsigned EN_BIT    = 0;
  localparam int unsigned START_LSB = 8;
  localparam int unsigned DONE_LSB  = 16;
  localparam int unsigned IE_LSB    = 24;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Byte-lane merge of a write into the current 32-bit register image.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/buzzer_multi_axi_tone_ch.sv
// One tone channel: latches period/duration on start and emits a square wave
// of 2*period*dur clocks, pulsing done_o on natural completion.
module buzzer_tone_ch
  import buzzer_pkg::*;
#(
  parameter int unsigned PER_W = 24,
  parameter int unsigned DUR_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             start_i,
  input  logic [PER_W-1:0] period_i,
  input  logic [DUR_W-1:0] dur_i,
  output logic             busy_o,
  output logic             buzz_o,
  output logic             done_o
);

  ch_state_e        state_q, state_d;
  logic [PER_W-1:0] per_sh_q, per_sh_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic             buzz_q, buzz_d;

  always_comb begin
    state_d  = state_q;
    per_sh_d = per_sh_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    buzz_d   = buzz_q;
    done_o   = 1'b0;
    unique case (state_q)
      CH_IDLE: begin
        if (start_i && en_i && (period_i != '0) && (dur_i != '0)) begin
          state_d  = CH_RUN;
          per_sh_d = period_i;
          cnt_d    = period_i - 1'b1;
          rem_d    = dur_i;
          buzz_d   = 1'b1;
        end
      end
      CH_RUN: begin
        if (!en_i) begin
          state_d = CH_IDLE;
          buzz_d  = 1'b0;
        end else if (cnt_q == '0) begin
          cnt_d = per_sh_q - 1'b1;
          if (buzz_q) begin
            buzz_d = 1'b0;
          end else if (rem_q == DUR_W'(1)) begin
            // End of the final low phase: the run spans whole cycles only.
            state_d = CH_IDLE;
            done_o  = 1'b1;
          end else begin
            rem_d  = rem_q - 1'b1;
            buzz_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= CH_IDLE;
      per_sh_q <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      buzz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_sh_q <= per_sh_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      buzz_q   <= buzz_d;
    end
  end

  assign busy_o = (state_q == CH_RUN);
  assign buzz_o = buzz_q;

endmodule

// File: rtl/buzzer_multi_axi.sv
// AXI4-Lite slave with NUM_CH independent tone channels.
// Define BUZZER_IRQ_EN to add per-channel IE bits and a registered irq_o.
module buzzer_multi_axi
  import buzzer_pkg::*;
#(
  parameter int unsigned NUM_CH             = 4,
  parameter int unsigned PER_W              = 24,
  parameter int unsigned DUR_W              = 16,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_CH-1:0]               buzzer_o,
  output logic                            irq_o
);

  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;

  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0] rdata_q, rd_word;
  logic        wr_fire, rd_fire;
  logic [AW-1:0] wr_addr, rd_addr;

  logic              en_q, en_d;
  logic [NUM_CH-1:0] done_q, done_d, done_set, done_clr, busy, start;
  logic [PER_W-1:0]  period_q [NUM_CH];
  logic [PER_W-1:0]  period_d [NUM_CH];
  logic [DUR_W-1:0]  dur_q [NUM_CH];
  logic [DUR_W-1:0]  dur_d [NUM_CH];

`ifdef BUZZER_IRQ_EN
  logic [NUM_CH-1:0] ie_q, ie_d;
  logic              irq_q;
`endif

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_fire = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = arready_q & S_AXI_ARVALID;
  assign wr_addr = {S_AXI_AWADDR[AW-1:2], 2'b00};
  assign rd_addr = {S_AXI_ARADDR[AW-1:2], 2'b00};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
      if (wr_fire) bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;
      arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

  // en_d feeds the channels so EN+START in one write starts, and EN=0 aborts at the write edge.
  always_comb begin
    en_d     = en_q;
    start    = '0;
    done_clr = '0;
    period_d = period_q;
    dur_d    = dur_q;
`ifdef BUZZER_IRQ_EN
    ie_d     = ie_q;
`endif
    if (wr_fire) begin
      if (wr_addr == AW'(CTRL_OFF)) begin
        if (S_AXI_WSTRB[0]) en_d = S_AXI_WDATA[EN_BIT];
        if (S_AXI_WSTRB[1]) start = S_AXI_WDATA[START_LSB +: NUM_CH];
`ifdef BUZZER_IRQ_EN
        if (S_AXI_WSTRB[3]) ie_d = S_AXI_WDATA[IE_LSB +: NUM_CH];
`endif
      end
      if ((wr_addr == AW'(STATUS_OFF)) && S_AXI_WSTRB[2]) begin
        done_clr = S_AXI_WDATA[DONE_LSB +: NUM_CH];
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_addr == AW'(CH_BASE + CH_STRIDE * k)) begin
          period_d[k] = PER_W'(apply_strb(32'(period_q[k]), S_AXI_WDATA, S_AXI_WSTRB));
        end
        if (wr_addr == AW'(CH_BASE + CH_STRIDE * k + 4)) begin
          dur_d[k] = DUR_W'(apply_strb(32'(dur_q[k]), S_AXI_WDATA, S_AXI_WSTRB));
        end
      end
    end
    // A completion in the same cycle as a W1C keeps DONE set.
    done_d = (done_q & ~done_clr) | done_set;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      en_q     <= 1'b0;
      done_q   <= '0;
      period_q <= '{default: '0};
      dur_q    <= '{default: '0};
    end else begin
      en_q     <= en_d;
      done_q   <= done_d;
      period_q <= period_d;
      dur_q    <= dur_d;
    end
  end

`ifdef BUZZER_IRQ_EN
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ie_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= |(done_q & ie_q);
    end
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    if (rd_addr == AW'(CTRL_OFF)) begin
      rd_word[EN_BIT] = en_q;
`ifdef BUZZER_IRQ_EN
      rd_word[IE_LSB +: NUM_CH] = ie_q;
`endif
    end
    if (rd_addr == AW'(STATUS_OFF)) begin
      rd_word[NUM_CH-1:0]         = busy;
      rd_word[DONE_LSB +: NUM_CH] = done_q;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_addr == AW'(CH_BASE + CH_STRIDE * k)) rd_word = 32'(period_q[k]);
      if (rd_addr == AW'(CH_BASE + CH_STRIDE * k + 4)) rd_word = 32'(dur_q[k]);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    buzzer_tone_ch #(
      .PER_W(PER_W),
      .DUR_W(DUR_W)
    ) u_ch (
      .clk_i   (S_AXI_ACLK),
      .rst_ni  (S_AXI_ARESETN),
      .en_i    (en_d),
      .start_i (start[k]),
      .period_i(period_q[k]),
      .dur_i   (dur_q[k]),
      .busy_o  (busy[k]),
      .buzz_o  (buzzer_o[k]),
      .done_o  (done_set[k])
    );
  end

endmodule

// File: tb/tb_buzzer_multi_axi.sv
// Scoreboard bench for buzzer_multi_axi: reads push expected data, a negedge
// monitor pops and compares; tone timing is checked against hand-derived values.
module tb_buzzer_multi_axi;

  localparam int NUM_CH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, arvalid = 0;
  logic        bready = 1, rready = 1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [NUM_CH-1:0] buzzer_o;
  logic        irq_o;

  buzzer_multi_axi dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .buzzer_o     (buzzer_o),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [33:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0, n_err = 0;
  int   busy_cnt[NUM_CH];
  logic irq_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NUM_CH; k++) busy_cnt[k] += int'(dut.busy[k]);
      if (irq_o) irq_seen = 1'b1;
      if (rvalid) begin
        if (sb.size() == 0) begin
          check("rd_unexpected", {32'd0, rdata}, 64'hDEAD);
        end else begin
          mon_e = sb.pop_front();
          check(mon_e.name, {30'd0, rresp, rdata}, {30'd0, mon_e.data});
        end
      end
      if (bvalid) check("bresp", {62'd0, bresp}, 64'd0);
    end
  end

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!awready) check("aw_timeout", {63'd0, awready}, 64'd1);
    @(posedge clk);
    #1 awvalid = 0; wvalid = 0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    int   n;
    e.name = name;
    e.data = {2'b00, exp};
    sb.push_back(e);
    araddr = a; arvalid = 1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!arready) check("ar_timeout", {63'd0, arready}, 64'd1);
    @(posedge clk);
    #1 arvalid = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input logic [NUM_CH-1:0] mask, input string name);
    int n;
    n = 0;
    while (((dut.busy & mask) != '0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if ((dut.busy & mask) != '0) check(name, {60'd0, dut.busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] wave, exp_wave;
    int          len, c0;
    int          cs[NUM_CH];
    logic [4:0]  irq_hist;

    repeat (3) @(negedge clk);
    check("reset_outputs", {57'd0, awready, wready, arready, bvalid, rvalid, buzzer_o[0], irq_o},
          64'd0);
    check("reset_buzzers", {60'd0, buzzer_o}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    rd(6'h00, 32'h0, "rst_ctrl");
    rd(6'h04, 32'h0, "rst_status");
    rd(6'h08, 32'h0, "rst_period0");

    // Register access and masking
    wr(6'h18, 32'hFF12_3456, 4'hF);
    wr(6'h1C, 32'h1234_BEEF, 4'hF);
    rd(6'h18, 32'h0012_3456, "period2_mask");
    rd(6'h1C, 32'h0000_BEEF, "dur2_mask");
    wr(6'h18, 32'h0000_00AA, 4'b0001);
    rd(6'h18, 32'h0012_34AA, "period2_strb");
    rd(6'h3C, 32'h0, "unmapped");

    // Single tone: P=5, D=3 -> 30 clocks, high 5 / low 5
    wr(6'h08, 32'd5, 4'hF);
    wr(6'h0C, 32'd3, 4'hF);
    wr(6'h00, 32'h0101, 4'hF);
    wave = '0;
    exp_wave = '0;
    for (int i = 0; i < 30; i++) exp_wave[i] = ((i / 5) % 2) == 0;
    len = 0;
    @(negedge clk);
    while (dut.busy[0] && len < 64) begin
      wave[len] = buzzer_o[0];
      len++;
      @(negedge clk);
    end
    check("tone0_busy_len", 64'(len), 64'd30);
    check("tone0_wave", wave, exp_wave);
    check("tone0_idle_out", {63'd0, buzzer_o[0]}, 64'd0);
    rd(6'h04, 32'h0001_0000, "tone0_done");
    wr(6'h04, 32'h0001_0000, 4'hF);
    rd(6'h04, 32'h0, "tone0_w1c");

    // Start filtering
    wr(6'h10, 32'd0, 4'hF);
    wr(6'h14, 32'd2, 4'hF);
    wr(6'h00, 32'h0201, 4'hF);
    @(negedge clk);
    check("start_p0", {62'd0, dut.busy[1], buzzer_o[1]}, 64'd0);
    rd(6'h04, 32'h0, "start_p0_status");
    wr(6'h10, 32'd3, 4'hF);
    wr(6'h00, 32'h0200, 4'hF);
    @(negedge clk);
    check("start_en0", {62'd0, dut.busy[1], buzzer_o[1]}, 64'd0);
    rd(6'h04, 32'h0, "start_en0_status");

    c0 = busy_cnt[0];
    wr(6'h00, 32'h0101, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    wr(6'h00, 32'h0101, 4'hF);
    wait_idle(4'b0001, "restart_timeout");
    check("restart_len", 64'(busy_cnt[0] - c0), 64'd30);
    rd(6'h04, 32'h0001_0000, "restart_done");
    wr(6'h04, 32'h0001_0000, 4'hF);

    // Abort by clearing EN mid-run
    wr(6'h00, 32'h0101, 4'hF);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("abort_pre_busy", {63'd0, dut.busy[0]}, 64'd1);
    wr(6'h00, 32'h0000, 4'hF);
    @(negedge clk);
    check("abort_outputs", {62'd0, dut.busy[0], buzzer_o[0]}, 64'd0);
    rd(6'h04, 32'h0, "abort_no_done");

    // Parallel channels: PERIOD_k = k+1, DUR_k = 2
    for (int k = 0; k < NUM_CH; k++) begin
      wr(6'(8 + 8 * k), 32'(k + 1), 4'hF);
      wr(6'(12 + 8 * k), 32'd2, 4'hF);
    end
    for (int k = 0; k < NUM_CH; k++) cs[k] = busy_cnt[k];
    wr(6'h00, 32'h0F01, 4'hF);
    @(negedge clk);
    check("par_busy_all", {56'd0, dut.busy, buzzer_o}, 64'hFF);
    wr(6'h20, 32'd9, 4'hF);
    wait_idle(4'hF, "par_timeout");
    for (int k = 0; k < NUM_CH; k++) begin
      check($sformatf("par_len%0d", k), 64'(busy_cnt[k] - cs[k]), 64'(4 * (k + 1)));
    end
    rd(6'h20, 32'd9, "par_period3_new");
    rd(6'h04, 32'h000F_0000, "par_done");
    wr(6'h04, 32'h000F_0000, 4'hF);
    rd(6'h04, 32'h0, "par_w1c");

    // Interrupt: P0=1, D0=1 -> DONE at 2nd edge, irq one edge later
    wr(6'h08, 32'd1, 4'hF);
    wr(6'h0C, 32'd1, 4'hF);
`ifdef BUZZER_IRQ_EN
    wr(6'h00, 32'h0100_0001, 4'hF);
    rd(6'h00, 32'h0100_0001, "irq_ctrl_ie");
    wr(6'h00, 32'h0100_0101, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      irq_hist[i] = irq_o;
    end
    check("irq_timing", {59'd0, irq_hist}, 64'b11000);
    wr(6'h04, 32'h0001_0000, 4'hF);
    repeat (2) @(negedge clk);
    check("irq_clear", {63'd0, irq_o}, 64'd0);
`else
    wr(6'h00, 32'h0100_0001, 4'hF);
    rd(6'h00, 32'h0000_0001, "noirq_ctrl_ie");
    wr(6'h00, 32'h0100_0101, 4'hF);
    repeat (6) @(negedge clk);
    rd(6'h04, 32'h0001_0000, "noirq_done");
    check("noirq_stays0", {63'd0, irq_seen}, 64'd0);
    wr(6'h04, 32'h0001_0000, 4'hF);
`endif

    // Asynchronous reset mid-run
    wr(6'h08, 32'd5, 4'hF);
    wr(6'h0C, 32'd3, 4'hF);
    wr(6'h00, 32'h0101, 4'hF);
    repeat (3) @(negedge clk);
    check("rst_pre_buzz", {63'd0, buzzer_o[0]}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_out", {54'd0, buzzer_o, dut.busy, irq_o, rvalid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(6'h00, 32'h0, "rst_ctrl_after");
    rd(6'h08, 32'h0, "rst_period_after");

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
